read_ptr_empty_ctrl: RTL and testbench
======================================

Name: read_ptr_empty_ctrl

Overview:
Read-domain pointer and empty-flag controller for the dual-clock asynchronous FIFO. It consumes the Gray-coded write pointer after it has been synchronized into rclk by the two-flop synchronizer, and maintains the binary and Gray read pointers. It drives the memory read address and the Gray read pointer that goes to the write-domain synchronizer. It also generates the empty, almost-empty, fill-level and underflow status seen by the read-side user.

Parameters:
ADDRESS_SIZE, 4, FIFO address width; depth = 2**ADDRESS_SIZE; pointers are ADDRESS_SIZE+1 bits.
ALMOST_EMPTY_THRESH, 2, ralmost_empty asserts when the fill level is less than or equal to this value; legal range 0..2**ADDRESS_SIZE.

Ports:
rclk  input  1  read clock
rrst_n  input  1  asynchronous active-low reset, read domain
rinc  input  1  read request; pops one word when not empty
rq2_write_ptr  input  ADDRESS_SIZE+1  Gray write pointer, already synchronized to rclk
underflow_clr  input  1  clears the sticky runderflow flag
read_addr  output  ADDRESS_SIZE  memory read address = rbin[ADDRESS_SIZE-1:0]
read_ptr  output  ADDRESS_SIZE+1  registered Gray read pointer, to the write-domain synchronizer
rempty  output  1  FIFO empty, registered
ralmost_empty  output  1  level is at or below ALMOST_EMPTY_THRESH, registered
rlevel  output  ADDRESS_SIZE+1  words available, 0..2**ADDRESS_SIZE, registered
runderflow  output  1  sticky: a read was attempted while empty

Behaviour:
- Reset (rrst_n low, asynchronous): rbin=0, read_ptr=0, rempty=1, ralmost_empty=1, rlevel=0, runderflow=0. read_addr=0 follows from rbin.
- Pointer update, per rclk:
  - rbin_next = rbin + (rinc & ~rempty), wrapping modulo 2**(ADDRESS_SIZE+1).
  - rgray_next = (rbin_next>>1) ^ rbin_next.
  - rbin <= rbin_next; read_ptr <= rgray_next.
  - read_ptr changes by exactly one bit per pop, or not at all. This is the Gray invariant relied on by the synchronizer.
- Empty: rempty <= (rgray_next == rq2_write_ptr). It is computed from next-state values, so popping the last word sets rempty in the same edge with no extra lag. rempty deasserts one rclk after rq2_write_ptr changes. End-to-end latency from a write to rempty falling is therefore the synchronizer's 2 rclk plus 1.
- Read data timing: read_addr points at the word currently presented; a pop advances it on the edge where rinc is sampled high.
- Level calculation:
  - wbin_s = Gray-to-binary of rq2_write_ptr, computed combinationally (MSB-down XOR prefix).
  - rlevel <= wbin_s - rbin_next, modulo 2**(ADDRESS_SIZE+1).
  - The result never exceeds 2**ADDRESS_SIZE when the write side is correct.
  - ralmost_empty <= (that same next level <= ALMOST_EMPTY_THRESH).
- Underflow: rinc && rempty sets runderflow on the next edge and leaves the pointers unchanged. underflow_clr clears it. If set and clear occur in the same cycle, set wins.
- Wrap-around: at depth 16, rbin goes 31->0 and read_ptr goes 10000b->00000b. This is a one-bit change and requires no special case; level arithmetic remains correct across the wrap.
- Reset mid-operation: all state returns to reset values immediately. The write side must be reset concurrently; this block does no re-alignment.
- Level is a conservative estimate: the synchronized write pointer is 2 rclk stale, so rlevel may under-report and never over-reports.

Test Plan:
- Reset with rq2_write_ptr=0 -> rempty=1, ralmost_empty=1, rlevel=0, read_ptr=0, read_addr=0, runderflow=0.
- Drive rq2_write_ptr through the Gray codes for write counts 1..5 (00001, 00011, 00010, 00110, 00111), no reads -> rempty falls one cycle after the first change, rlevel reaches 5, ralmost_empty falls when rlevel becomes 3.
- With 5 words available, hold rinc for 5 cycles -> read_addr steps 0..4 then 5, read_ptr=00111, rlevel counts 4,3,2,1,0, rempty rises on the edge that pops the 5th word.
- With the FIFO empty, pulse rinc -> runderflow=1, read_ptr unchanged. Pulse underflow_clr -> runderflow=0. Assert rinc&rempty together with underflow_clr -> runderflow stays 1.
- Wrap test: write 30, read 30, write 4 (wbin=34 mod 32 = 2, Gray 00011), read 4 -> rbin passes 31->0, read_addr goes 14,15,0,1, rlevel goes 4->0, read_ptr ends at 00011, rempty=1. Every read_ptr transition changes exactly one bit.
- Assert rrst_n low while 3 words are pending -> outputs return to reset values asynchronously, without waiting for an rclk edge.

Source files
------------

// File: rtl/read_ptr_empty_ctrl.sv
// Read-domain pointer and empty/level controller for a dual-clock FIFO.
// Consumes the rclk-synchronized Gray write pointer; all status outputs are registered.
module read_ptr_empty_ctrl #(
    parameter int ADDRESS_SIZE        = 4,
    parameter int ALMOST_EMPTY_THRESH = 2
) (
    input  logic                    rclk,
    input  logic                    rrst_n,
    input  logic                    rinc,
    input  logic [ADDRESS_SIZE:0]   rq2_write_ptr,
    input  logic                    underflow_clr,
    output logic [ADDRESS_SIZE-1:0] read_addr,
    output logic [ADDRESS_SIZE:0]   read_ptr,
    output logic                    rempty,
    output logic                    ralmost_empty,
    output logic [ADDRESS_SIZE:0]   rlevel,
    output logic                    runderflow
);

    localparam int PW = ADDRESS_SIZE + 1;
    localparam logic [PW-1:0] AE_THRESH = PW'(ALMOST_EMPTY_THRESH);

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // MSB-down XOR prefix
    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0] rbin_r;
    logic [PW-1:0] read_ptr_r;
    logic [PW-1:0] rlevel_r;
    logic          rempty_r;
    logic          ralmost_empty_r;
    logic          runderflow_r;

    logic          pop_s;
    logic [PW-1:0] rbin_next_s;
    logic [PW-1:0] rgray_next_s;
    logic [PW-1:0] wbin_s;
    logic [PW-1:0] level_next_s;
    logic          underflow_next_s;

    // Next-state pointer, level and sticky underflow computation
    always_comb begin
        pop_s        = rinc & ~rempty_r;
        rbin_next_s  = rbin_r + {{ADDRESS_SIZE{1'b0}}, pop_s};
        rgray_next_s = bin2gray(rbin_next_s);
        wbin_s       = gray2bin(rq2_write_ptr);
        level_next_s = wbin_s - rbin_next_s;
        // A new underflow event takes priority over a clear in the same cycle
        if (rinc && rempty_r) begin
            underflow_next_s = 1'b1;
        end else if (underflow_clr) begin
            underflow_next_s = 1'b0;
        end else begin
            underflow_next_s = runderflow_r;
        end
    end

    // Pointer and status registers, asynchronously reset to the empty state
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin_r          <= {PW{1'b0}};
            read_ptr_r      <= {PW{1'b0}};
            rlevel_r        <= {PW{1'b0}};
            rempty_r        <= 1'b1;
            ralmost_empty_r <= 1'b1;
            runderflow_r    <= 1'b0;
        end else begin
            rbin_r          <= rbin_next_s;
            read_ptr_r      <= rgray_next_s;
            rlevel_r        <= level_next_s;
            rempty_r        <= (rgray_next_s == rq2_write_ptr);
            ralmost_empty_r <= (level_next_s <= AE_THRESH);
            runderflow_r    <= underflow_next_s;
        end
    end

    assign read_addr     = rbin_r[ADDRESS_SIZE-1:0];
    assign read_ptr      = read_ptr_r;
    assign rlevel        = rlevel_r;
    assign rempty        = rempty_r;
    assign ralmost_empty = ralmost_empty_r;
    assign runderflow    = runderflow_r;

endmodule

// File: tb/tb_read_ptr_empty_ctrl.sv
// Scoreboard bench for read_ptr_empty_ctrl: driver queues hand-computed expectations,
// a negedge monitor pops and compares them and also checks the one-bit Gray step.
module tb_read_ptr_empty_ctrl;

    logic       rclk = 1'b0;
    logic       rrst_n;
    logic       rinc;
    logic [4:0] rq2_write_ptr;
    logic       underflow_clr;
    logic [3:0] read_addr;
    logic [4:0] read_ptr;
    logic       rempty;
    logic       ralmost_empty;
    logic [4:0] rlevel;
    logic       runderflow;

    read_ptr_empty_ctrl #(.ADDRESS_SIZE(4), .ALMOST_EMPTY_THRESH(2)) dut (
        .rclk(rclk), .rrst_n(rrst_n), .rinc(rinc), .rq2_write_ptr(rq2_write_ptr),
        .underflow_clr(underflow_clr), .read_addr(read_addr), .read_ptr(read_ptr),
        .rempty(rempty), .ralmost_empty(ralmost_empty), .rlevel(rlevel),
        .runderflow(runderflow)
    );

    always #5 rclk = ~rclk;

    typedef struct {
        string      tag;
        logic       e;
        logic       ae;
        logic [4:0] lvl;
        logic [4:0] ptr;
        logic [3:0] addr;
        logic       uf;
    } exp_t;

    exp_t       exp_q[$];
    int         n_cmp    = 0;
    int         n_bad    = 0;
    logic [4:0] prev_ptr = 5'd0;

    function automatic logic [4:0] g(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic exp_t mk(input string tag, input logic e, input logic ae,
                                input logic [4:0] lvl, input logic [4:0] ptr,
                                input logic [3:0] addr, input logic uf);
        exp_t x;
        x.tag = tag; x.e = e; x.ae = ae; x.lvl = lvl; x.ptr = ptr; x.addr = addr; x.uf = uf;
        return x;
    endfunction

    task automatic check(input exp_t x);
        n_cmp++;
        if (rempty !== x.e || ralmost_empty !== x.ae || rlevel !== x.lvl ||
            read_ptr !== x.ptr || read_addr !== x.addr || runderflow !== x.uf) begin
            n_bad++;
            $display("FAIL %s @%0t: got empty=%b aempty=%b level=%0d ptr=%b addr=%0d uflow=%b; want empty=%b aempty=%b level=%0d ptr=%b addr=%0d uflow=%b",
                     x.tag, $time, rempty, ralmost_empty, rlevel, read_ptr, read_addr, runderflow,
                     x.e, x.ae, x.lvl, x.ptr, x.addr, x.uf);
        end
    endtask

    // Monitor: one expectation per rclk edge, plus the single-bit Gray step check
    always @(negedge rclk) begin
        exp_t x;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            check(x);
            n_cmp++;
            if ($countones(prev_ptr ^ read_ptr) > 1) begin
                n_bad++;
                $display("FAIL gray_step %s: got %b -> %b, want at most one bit change",
                         x.tag, prev_ptr, read_ptr);
            end
            prev_ptr = read_ptr;
        end
    end

    task automatic step(input logic ri, input logic [4:0] wp, input logic clr,
                        input logic e, input logic ae, input logic [4:0] lvl,
                        input logic [4:0] ptr, input logic [3:0] addr, input logic uf,
                        input string tag);
        rinc          = ri;
        rq2_write_ptr = wp;
        underflow_clr = clr;
        @(posedge rclk);
        exp_q.push_back(mk(tag, e, ae, lvl, ptr, addr, uf));
        @(negedge rclk);
    endtask

    initial begin
        rrst_n        = 1'b0;
        rinc          = 1'b0;
        underflow_clr = 1'b0;
        rq2_write_ptr = 5'd0;
        repeat (2) @(negedge rclk);
        #1 check(mk("reset", 1'b1, 1'b1, 5'd0, 5'd0, 4'd0, 1'b0));
        @(negedge rclk);
        rrst_n = 1'b1;
        step(1'b0, 5'b00000, 1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 4'd0, 1'b0, "idle");

        // Writes arrive, no reads
        step(1'b0, 5'b00001, 1'b0, 1'b0, 1'b1, 5'd1, 5'd0, 4'd0, 1'b0, "wr1");
        step(1'b0, 5'b00011, 1'b0, 1'b0, 1'b1, 5'd2, 5'd0, 4'd0, 1'b0, "wr2");
        step(1'b0, 5'b00010, 1'b0, 1'b0, 1'b0, 5'd3, 5'd0, 4'd0, 1'b0, "wr3");
        step(1'b0, 5'b00110, 1'b0, 1'b0, 1'b0, 5'd4, 5'd0, 4'd0, 1'b0, "wr4");
        step(1'b0, 5'b00111, 1'b0, 1'b0, 1'b0, 5'd5, 5'd0, 4'd0, 1'b0, "wr5");

        // Drain five words
        step(1'b1, 5'b00111, 1'b0, 1'b0, 1'b0, 5'd4, 5'b00001, 4'd1, 1'b0, "rd1");
        step(1'b1, 5'b00111, 1'b0, 1'b0, 1'b0, 5'd3, 5'b00011, 4'd2, 1'b0, "rd2");
        step(1'b1, 5'b00111, 1'b0, 1'b0, 1'b1, 5'd2, 5'b00010, 4'd3, 1'b0, "rd3");
        step(1'b1, 5'b00111, 1'b0, 1'b0, 1'b1, 5'd1, 5'b00110, 4'd4, 1'b0, "rd4");
        step(1'b1, 5'b00111, 1'b0, 1'b1, 1'b1, 5'd0, 5'b00111, 4'd5, 1'b0, "rd5");

        // Underflow set, clear, and set-beats-clear
        step(1'b1, 5'b00111, 1'b0, 1'b1, 1'b1, 5'd0, 5'b00111, 4'd5, 1'b1, "uf_set");
        step(1'b0, 5'b00111, 1'b1, 1'b1, 1'b1, 5'd0, 5'b00111, 4'd5, 1'b0, "uf_clr");
        step(1'b1, 5'b00111, 1'b1, 1'b1, 1'b1, 5'd0, 5'b00111, 4'd5, 1'b1, "uf_set_wins");
        step(1'b0, 5'b00111, 1'b1, 1'b1, 1'b1, 5'd0, 5'b00111, 4'd5, 1'b0, "uf_clr2");

        // Full FIFO (level 16), then drain to rbin 21
        step(1'b0, g(5'd21), 1'b0, 1'b0, 1'b0, 5'd16, 5'b00111, 4'd5, 1'b0, "full");
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, g(5'd21), 1'b0, (i == 16), ((16 - i) <= 2), 5'(16 - i),
                 g(5'(5 + i)), 4'(5 + i), 1'b0, "full_drain");
        end

        // Advance to rbin 30
        step(1'b0, g(5'd30), 1'b0, 1'b0, 1'b0, 5'd9, g(5'd21), 4'd5, 1'b0, "wr_to30");
        for (int i = 1; i <= 9; i++) begin
            step(1'b1, g(5'd30), 1'b0, (i == 9), ((9 - i) <= 2), 5'(9 - i),
                 g(5'(21 + i)), 4'(5 + i), 1'b0, "rd_to30");
        end

        // Wrap: write side at 34 mod 32 = 2, read across 31 -> 0
        step(1'b0, 5'b00011, 1'b0, 1'b0, 1'b0, 5'd4, 5'b10001, 4'd14, 1'b0, "wrap_wr");
        step(1'b1, 5'b00011, 1'b0, 1'b0, 1'b0, 5'd3, 5'b10000, 4'd15, 1'b0, "wrap_rd1");
        step(1'b1, 5'b00011, 1'b0, 1'b0, 1'b1, 5'd2, 5'b00000, 4'd0,  1'b0, "wrap_rd2");
        step(1'b1, 5'b00011, 1'b0, 1'b0, 1'b1, 5'd1, 5'b00001, 4'd1,  1'b0, "wrap_rd3");
        step(1'b1, 5'b00011, 1'b0, 1'b1, 1'b1, 5'd0, 5'b00011, 4'd2,  1'b0, "wrap_rd4");

        // Three words pending, then asynchronous reset between edges
        step(1'b0, 5'b00111, 1'b0, 1'b0, 1'b0, 5'd3, 5'b00011, 4'd2, 1'b0, "pend3");
        #2 rrst_n = 1'b0;
        #1 check(mk("async_reset", 1'b1, 1'b1, 5'd0, 5'd0, 4'd0, 1'b0));
        prev_ptr      = 5'd0;
        rinc          = 1'b0;
        rq2_write_ptr = 5'd0;
        repeat (2) @(negedge rclk);
        rrst_n = 1'b1;
        step(1'b0, 5'b00000, 1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 4'd0, 1'b0, "post_reset");

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge rclk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
